// File: rtl/systolic_array_ctrl_if.sv
`default_nettype none
//============================================================================
// Module   : systolic_array_ctrl_if
// Purpose  : Bundle of every non-clock/reset signal of systolic_array_ctrl:
//            the job input handshake, the array drive/observe bus and the
//            result output handshake.
// Members  : in_valid, in_ready, mat_a[16*DW], mat_b[16*DW]  job input
//            arr_res, arr_a[4*DW], arr_b[4*DW], arr_out[16*ACC_W] array
//            result[16*ACC_W], out_valid, out_ready            job output
//            job_count[16]                                     statistics
// Modports : slave  - the controller
//            master - the environment (requester, array, consumer)
// Revision : 1.0 - initial release
//============================================================================
interface systolic_array_ctrl_if #(
   parameter int DW    = 4,
   parameter int ACC_W = 10
);
   logic                  in_valid;
   logic                  in_ready;
   logic [16*DW-1:0]      mat_a;
   logic [16*DW-1:0]      mat_b;
   logic                  arr_res;
   logic [4*DW-1:0]       arr_a;
   logic [4*DW-1:0]       arr_b;
   logic [16*ACC_W-1:0]   arr_out;
   logic [16*ACC_W-1:0]   result;
   logic                  out_valid;
   logic                  out_ready;
   logic [15:0]           job_count;

   modport slave (
      input  in_valid, mat_a, mat_b, arr_out, out_ready,
      output in_ready, arr_res, arr_a, arr_b, result, out_valid, job_count
   );

   modport master (
      output in_valid, mat_a, mat_b, arr_out, out_ready,
      input  in_ready, arr_res, arr_a, arr_b, result, out_valid, job_count
   );
endinterface
`default_nettype wire

// File: rtl/systolic_array_ctrl.sv
`default_nettype none
//============================================================================
// Module   : systolic_array_ctrl
// Purpose  : Sequencer for a 4x4 systolic matrix multiplier. Accepts one pair
//            of 4x4 matrices, resets the array, streams the skewed row and
//            column wavefronts, drains the pipeline, captures the
//            accumulator bus and holds it behind a valid/ready handshake.
// Ports    : clk  - clock, rising edge
//            res  - synchronous active-high reset
//            bus  - systolic_array_ctrl_if.slave (job in, array bus,
//                   result out, job_count)
// Options  : SYSCTL_JOB_COUNT_EN - when defined, job_count counts completed
//            output handshakes (saturating); otherwise it is tied to zero.
// Revision : 1.0 - initial release
//============================================================================
module systolic_array_ctrl #(
   parameter int DW        = 4,
   parameter int ACC_W     = 10,
   parameter int DRAIN_CYC = 4
) (
   input  logic                 clk,
   input  logic                 res,
   systolic_array_ctrl_if.slave bus
);

   localparam int MAT_W = 16 * DW;
   localparam int ROW_W = 4 * DW;
   localparam int RES_W = 16 * ACC_W;

   // Last FEED index: wavefronts k = 0..6 cover every i+j of a 4x4 grid.
   localparam logic [2:0] c_feed_last  = 3'd6;
   // DRAIN runs k = 0..DRAIN_CYC: DRAIN_CYC zero-feed cycles let the final
   // product settle into PE(3,3), the extra cycle presents the settled bus
   // for capture.
   localparam logic [2:0] c_drain_last = 3'(DRAIN_CYC);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [2:0]           r_k;
   logic [2:0]           w_k_next;

   logic [MAT_W-1:0]     r_mat_a;
   logic [MAT_W-1:0]     r_mat_b;
   logic [ROW_W-1:0]     r_arr_a;
   logic [ROW_W-1:0]     r_arr_b;
   logic [RES_W-1:0]     r_result;

   logic                 w_in_ready;
   logic                 w_out_valid;
   logic                 w_accept;
   logic                 w_capture;
   logic                 w_load_wave;
   logic [2:0]           w_wave_k;
   logic [ROW_W-1:0]     w_wave_a;
   logic [ROW_W-1:0]     w_wave_b;

   //------------------------------------------------------------------------
   // State register
   //------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (res) begin
         r_state <= S_IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_state_next;
         r_k     <= w_k_next;
      end
   end

   //------------------------------------------------------------------------
   // Next-state and control decode
   //------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_k_next     = r_k;
      w_in_ready   = 1'b0;
      w_out_valid  = 1'b0;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_load_wave  = 1'b0;
      w_wave_k     = '0;

      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_CLEAR;
            end
         end

         S_CLEAR: begin
            // Preload wavefront 0 so it sits on the array during FEED k=0.
            w_load_wave  = 1'b1;
            w_wave_k     = 3'd0;
            w_k_next     = 3'd0;
            w_state_next = S_FEED;
         end

         S_FEED: begin
            if (r_k == c_feed_last) begin
               w_k_next     = 3'd0;
               w_state_next = S_DRAIN;
            end else begin
               // Registers hold wavefront k now; load k+1 for the next cycle.
               w_load_wave = 1'b1;
               w_wave_k    = r_k + 3'd1;
               w_k_next    = r_k + 3'd1;
            end
         end

         S_DRAIN: begin
            if (r_k == c_drain_last) begin
               w_capture    = 1'b1;
               w_k_next     = 3'd0;
               w_state_next = S_DONE;
            end else begin
               w_k_next = r_k + 3'd1;
            end
         end

         S_DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) begin
               w_state_next = S_IDLE;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   //------------------------------------------------------------------------
   // Wavefront select: element (i,j) of either matrix belongs to wavefront
   // i+j. Row i of A drives a_i with A[i][k-i]; column j of B drives b_j
   // with B[k-j][j]. Both reduce to "pick the element whose i+j equals k".
   //------------------------------------------------------------------------
   always_comb begin
      w_wave_a = '0;
      w_wave_b = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (w_wave_k == 3'(i + j)) begin
               w_wave_a[i*DW +: DW] = r_mat_a[(4*i + j)*DW +: DW];
               w_wave_b[j*DW +: DW] = r_mat_b[(4*i + j)*DW +: DW];
            end
         end
      end
   end

   //------------------------------------------------------------------------
   // Datapath: job latch, array feed registers, result capture
   //------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (res) begin
         r_mat_a  <= '0;
         r_mat_b  <= '0;
         r_arr_a  <= '0;
         r_arr_b  <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_mat_a <= bus.mat_a;
            r_mat_b <= bus.mat_b;
         end
         // Anything other than an active wavefront load feeds zeros.
         if (w_load_wave) begin
            r_arr_a <= w_wave_a;
            r_arr_b <= w_wave_b;
         end else begin
            r_arr_a <= '0;
            r_arr_b <= '0;
         end
         if (w_capture) begin
            r_result <= bus.arr_out;
         end
      end
   end

   //------------------------------------------------------------------------
   // Completed-job counter
   //------------------------------------------------------------------------
`ifdef SYSCTL_JOB_COUNT_EN
   logic [15:0] r_job_count;

   always_ff @(posedge clk) begin
      if (res) begin
         r_job_count <= '0;
      end else if (w_out_valid && bus.out_ready && (r_job_count != 16'hFFFF)) begin
         r_job_count <= r_job_count + 16'd1;
      end
   end

   assign bus.job_count = r_job_count;
`else
   assign bus.job_count = 16'h0000;
`endif

   //------------------------------------------------------------------------
   // Outputs
   //------------------------------------------------------------------------
   // The array reset follows res combinationally so the array is cleared in
   // the same cycle as the controller.
   assign bus.arr_res   = res | (r_state == S_CLEAR);
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.arr_a     = r_arr_a;
   assign bus.arr_b     = r_arr_b;
   assign bus.result    = r_result;

endmodule
`default_nettype wire

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequencer for the 4x4 weight-free systolic_array multiplier.
- Accepts one pair of 4x4 matrices (4-bit unsigned elements) through a valid/ready handshake and clears the array.
- Streams the skewed row/column wavefronts into a0..a3 / b0..b3, drains the pipeline, then captures the 160-bit accumulator bus.
- Holds the captured result behind a valid/ready output handshake.

Parameters:
- DW, 4, element width of A/B entries.
- ACC_W, 10, width of one accumulator in the array output bus.
- DRAIN_CYC, 4, zero-feed cycles after the last wavefront before capture.

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  reset; one clock; reset is synchronous and active-high.
- in_valid  in  1  request: mat_a/mat_b are valid.
- in_ready  out  1  controller can accept a job; high only in IDLE.
- mat_a  in  64  A[i][j] at bits [(4i+j)*4 +: 4].
- mat_b  in  64  B[i][j] at bits [(4i+j)*4 +: 4].
- arr_res  out  1  reset to systolic_array.
- arr_a  out  16  a0..a3 packed, a_i at [4i +: 4].
- arr_b  out  16  b0..b3 packed, b_j at [4j +: 4].
- arr_out  in  160  systolic_array out bus; captured verbatim.
- result  out  160  captured array output.
- out_valid  out  1  result holds a completed product.
- out_ready  in  1  consumer accepts result.
- job_count  out  16  completed-job counter (see Optional Feature).

Behaviour:
- States: IDLE, CLEAR, FEED, DRAIN, DONE; 3-bit feed/drain counter k.
- Reset (res=1 at an edge, in any state):
  - State goes to IDLE; k=0; arr_a=arr_b=0; result=0; out_valid=0.
  - arr_res = res OR (state==CLEAR), combinational, so the array is reset with the controller.
  - Internal A/B copies cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch mat_a/mat_b internally and go to CLEAR.
  - mat_a/mat_b changes after acceptance are ignored.
- CLEAR:
  - One cycle; arr_res=1, arr_a=arr_b=0.
  - Go to FEED with k=0.
- FEED:
  - 7 cycles, k=0..6.
  - Row i: arr_a[i] = A[i][k-i] when 0<=k-i<=3, else 0.
  - Column j: arr_b[j] = B[k-j][j] when 0<=k-j<=3, else 0.
  - arr_a/arr_b are registered; the value for cycle k is visible on the array inputs during FEED cycle k.
  - At k==6, go to DRAIN with k=0.
- DRAIN:
  - DRAIN_CYC cycles with arr_a=arr_b=0; lets the last term reach PE(3,3).
  - On the last drain cycle, result <= arr_out and go to DONE.
- DONE:
  - out_valid=1; result stable.
  - out_ready=1 causes out_valid to drop next cycle and the state to return to IDLE.
  - in_ready stays 0 in DONE; a new job is accepted no earlier than the cycle after the handshake completes.
- Latency: out_valid rises exactly 1+7+DRAIN_CYC+1 = 13 clocks after the accepting edge (defaults). Minimum job period 14 clocks.
- Width rules:
  - Max element 15; max dot product 4*225 = 900 < 1024, so ACC_W=10 cannot overflow.
  - Controller performs no arithmetic on result.
- Back-pressure: out_ready low holds DONE indefinitely; result and out_valid stay unchanged and arr_a/arr_b stay 0.
- Reset mid-FEED or mid-DRAIN: the job is discarded, nothing is captured, out_valid stays 0, in_ready=1 the cycle after res deasserts.
- in_valid while busy: ignored, no latching; the requester must hold it until in_ready.

Optional Feature:
- Macro SYSCTL_JOB_COUNT_EN.
- Defined:
  - job_count increments by 1 on each out_valid&&out_ready handshake.
  - Saturates at 16'hFFFF.
  - Cleared by res.
- Undefined: job_count is tied to 16'h0000 and no counter register is synthesized. The port remains present so the interface is identical.

Test Plan:
- All-2 matrices (mat_a=mat_b=64'h2222_2222_2222_2222): accept at edge T -> out_valid at T+13, every 10-bit field of result = 10'd16; during FEED, arr_a sequence matches a0..a3 = (2,0,0,0),(2,2,0,0),(2,2,2,0),(2,2,2,2),(0,2,2,2),(0,0,2,2),(0,0,0,2).
- Identity A times B with B[i][j]=4i+j (mod 16) -> C fields equal B entries; all-15 A and B -> every field = 10'd900.
- Skew check with A[i][j]=4i+j+1 and B=0: per FEED cycle k, arr_a[i] = A[i][k-i] or 0 exactly; arr_res high only in CLEAR.
- Back-pressure: out_ready=0 for 20 cycles after out_valid -> result/out_valid stable and in_ready=0; a pulse of new in_valid is not accepted; out_ready=1 -> IDLE, next job accepted one cycle later.
- res asserted at FEED k=3 -> next cycle IDLE, arr_a=arr_b=0, arr_res=1 during res, out_valid never asserts; a following job gives the correct result.
- With SYSCTL_JOB_COUNT_EN: three back-to-back jobs -> job_count = 3; res -> 0. Without the macro: job_count = 0 throughout.
